// File: rtl/gray_pkg.sv
// Shared Gray-code helpers. Functions work on 32-bit words; callers zero-extend
// narrower words and truncate the result back to their own width.
package gray_pkg;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits decode to zero, so lower bits stay correct after zero-extension.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // More than one set bit in the difference means the words are not Gray-adjacent.
  function automatic logic hamming_gt1(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    x = a ^ b;
    return (x & (x - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/gray_pipe_stage.sv
// Valid/ready register slice: captures a beat when enabled, holds it otherwise.
module gray_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         d_valid,
  input  logic [W-1:0] d,
  output logic         q_valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q       <= '0;
    end else if (en) begin
      q_valid <= d_valid;
      if (d_valid) q <= d;
    end
  end

endmodule

// File: rtl/gray_codec_pipe.sv
// Two-stage Gray encoder/decoder with valid/ready flow control and a
// Gray-adjacency check against the last accepted mode-1 word.
module gray_codec_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             out_adj_err
);

  logic             s1_valid, s2_valid;
  logic [WIDTH+1:0] s1_d, s1_q, s2_d, s2_q;
  logic             s2_adv, accept, adj;
  logic [WIDTH-1:0] hist, s1_word, conv;
  logic             hist_valid, s1_mode;

  assign s2_adv   = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist       <= '0;
      hist_valid <= 1'b0;
    end else if (accept && in_mode == MODE_G2B) begin
      hist       <= in_data;
      hist_valid <= 1'b1;
    end
  end

  // Adjacency is judged against history as it stood before this beat.
  assign adj  = (in_mode == MODE_G2B) && hist_valid &&
                hamming_gt1(32'(in_data), 32'(hist));
  assign s1_d = {in_data, in_mode, adj};

  gray_pipe_stage #(.W(WIDTH + 2)) u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (in_ready),
    .d_valid (in_valid),
    .d       (s1_d),
    .q_valid (s1_valid),
    .q       (s1_q)
  );

  assign s1_word = s1_q[WIDTH+1:2];
  assign s1_mode = s1_q[1];
  assign conv    = WIDTH'((s1_mode == MODE_G2B) ? gray2bin(32'(s1_word))
                                                : bin2gray(32'(s1_word)));
  assign s2_d    = {conv, s1_q[1:0]};

  gray_pipe_stage #(.W(WIDTH + 2)) u_s2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (s2_adv),
    .d_valid (s1_valid),
    .d       (s2_d),
    .q_valid (s2_valid),
    .q       (s2_q)
  );

  assign out_valid   = s2_valid;
  assign out_data    = s2_q[WIDTH+1:2];
  assign out_mode    = s2_q[1];
  assign out_adj_err = s2_q[0];

endmodule

// File: doc/gray_codec_pipe.md
GRAY_CODEC_PIPE -- requirements
Module: gray_codec_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: code word width in bits, legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream beat present.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-006 SHALL have port in_data, input, WIDTH bits: code word to convert.
REQ-007 SHALL have port in_mode, input, 1 bit: 0 = binary-to-Gray, 1 = Gray-to-binary.
REQ-008 SHALL have port out_valid, output, 1 bit: result beat present.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-010 SHALL have port out_data, output, WIDTH bits: converted word.
REQ-011 SHALL have port out_mode, output, 1 bit: in_mode carried with the beat.
REQ-012 SHALL have port out_adj_err, output, 1 bit: Gray adjacency violation flag for the beat.

Function
REQ-013 SHALL accept a beat when in_valid and in_ready are both high in the same cycle, and transfer a result when out_valid and out_ready are both high in the same cycle.
REQ-014 SHALL use a two-stage pipeline:
- S1 registers in_data, in_mode and the adjacency result.
- S2 registers the converted word.
- Each stage has its own valid bit.
REQ-015 SHALL give a latency of exactly 2 cycles from acceptance to out_valid when there is no backpressure, and SHALL sustain 1 beat per cycle.
REQ-016 SHALL advance S2 when S2 is empty or out_ready is high, and SHALL advance S1 into S2 when S1 is valid and S2 advances.
REQ-017 SHALL drive in_ready = !S1_valid || S2_advance; the path from out_ready to in_ready is combinational.
REQ-018 SHALL compute binary-to-Gray as g = b XOR (b >> 1).
REQ-019 SHALL compute Gray-to-binary as b[WIDTH-1] = g[WIDTH-1], and b[i] = b[i+1] XOR g[i] for each lower bit i.
REQ-020 SHALL hold out_data, out_mode and out_adj_err stable while out_valid is high and out_ready is low.
REQ-021 SHALL hold a history register with the last accepted in_data for which in_mode=1, plus a hist_valid flag.
REQ-022 SHALL set out_adj_err=1 only for a mode-1 beat with hist_valid=1 whose Hamming distance from the history register is greater than 1; equal words (distance 0) SHALL NOT flag.
REQ-023 SHALL drive out_adj_err=0 for mode-0 beats and for the first mode-1 beat after reset.
REQ-024 SHALL update the history only on acceptance of a mode-1 beat; mode-0 beats SHALL leave it unchanged.
REQ-025 SHALL never drop, duplicate or reorder beats under any out_ready pattern.

Reset
REQ-026 SHALL, on any cycle with rst_n low, clear both stage valid bits, hist_valid and all data, mode and flag registers to 0.
REQ-027 SHALL, in the first cycle after rst_n returns high, present out_valid=0, out_data=0, out_mode=0, out_adj_err=0 and in_ready=1.
REQ-028 SHALL discard any beats in flight when reset is asserted mid-stream, with no partial output.

Structure
REQ-029 SHALL place the following in shared package gray_pkg, and no other typedefs or constants:
- localparams MODE_B2G=0 and MODE_G2B=1.
- functions bin2gray and gray2bin.
- function hamming_gt1.
REQ-030 SHALL instantiate exactly one sub-module, gray_pipe_stage: a parametrised valid/ready register slice used twice.

Verification
REQ-031 SHALL run all of the following at WIDTH=4:
- Mode 1, in_data 0110 -> out_data 0100 two cycles later, out_adj_err=0.
- Mode 0, in_data 0101 -> out_data 0111, out_mode=0.
- Mode-1 sequence 0000, 0001, 0011, 0111, 0000 -> out_adj_err = 0, 0, 0, 0, 1.
- All 16 Gray codes in mode 1 back-to-back with out_ready=1 -> 16 consecutive correct outputs, in_ready never low.
- out_ready held low 5 cycles while 3 beats are offered -> 2 beats accepted, in_ready low after that, out_data stable; on release all 3 beats exit in order.
- rst_n low for 1 cycle with both stages valid -> next cycle out_valid=0, in_ready=1; the next mode-1 beat 1111 gives out_adj_err=0.
